// File: rtl/fsm_trace_fifo_if.sv
// Read-side handshake bundle of the state-trace FIFO.
// The FIFO drives the head record; the consumer drives out_ready.
interface fsm_trace_fifo_if #(
  parameter int WIDTH    = 4,
  parameter int TS_WIDTH = 8
);
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_state;
  logic [TS_WIDTH-1:0] out_cycle;

  modport master (
    output out_valid,
    output out_state,
    output out_cycle,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_state,
    input  out_cycle,
    output out_ready
  );
endinterface

// File: rtl/fsm_trace_fifo.sv
// Traces the fsm state code y into a FIFO of (state, cycle stamp) records,
// optionally keeping only state changes, drained over a valid/ready port.
module fsm_trace_fifo #(
  parameter int WIDTH       = 4,
  parameter int TS_WIDTH    = 8,
  parameter int DEPTH       = 16,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic [WIDTH-1:0]           y,
  fsm_trace_fifo_if.master           out_if,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0]       PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0]       CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0]       CNT_FULL = CW'(DEPTH);
  localparam logic [TS_WIDTH-1:0] TS_ONE  = TS_WIDTH'(1'b1);
  localparam logic                KEEP_ALL = (CHANGE_ONLY == 0);

  logic [WIDTH-1:0]    state_mem_q [DEPTH];
  logic [TS_WIDTH-1:0] cycle_mem_q [DEPTH];

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TS_WIDTH-1:0] stamp_q, stamp_d;
  logic [WIDTH-1:0]    last_y_q, last_y_d;
  logic                last_valid_q, last_valid_d;
  logic                overflow_q, overflow_d;

  logic push_req_s, push_s, pop_s, drop_s, full_s, empty_s, mem_we_s;

  assign empty_s    = (count_q == {CW{1'b0}});
  assign full_s     = (count_q == CNT_FULL);
  assign push_req_s = en & (KEEP_ALL | ~last_valid_q | (y != last_y_q));
  assign pop_s      = ~empty_s & out_if.out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;
  assign mem_we_s   = push_s & ~clear;

  // Next-state logic for pointers, occupancy, stamp, change tracking and overflow.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    stamp_d      = stamp_q;
    last_y_d     = last_y_q;
    last_valid_d = last_valid_q;
    overflow_d   = overflow_q;
    if (clear) begin
      wr_ptr_d     = {AW{1'b0}};
      rd_ptr_d     = {AW{1'b0}};
      count_d      = {CW{1'b0}};
      stamp_d      = {TS_WIDTH{1'b0}};
      last_y_d     = {WIDTH{1'b0}};
      last_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (en) begin
        stamp_d      = stamp_q + TS_ONE;
        last_y_d     = y;
        last_valid_d = 1'b1;
      end else begin
        stamp_d      = stamp_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      stamp_q      <= {TS_WIDTH{1'b0}};
      last_y_q     <= {WIDTH{1'b0}};
      last_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stamp_q      <= stamp_d;
      last_y_q     <= last_y_d;
      last_valid_q <= last_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Record storage; contents are only observable through an occupied slot.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      state_mem_q[wr_ptr_q] <= y;
      cycle_mem_q[wr_ptr_q] <= stamp_q;
    end
  end

  assign out_if.out_valid = ~empty_s;
  assign out_if.out_state = empty_s ? {WIDTH{1'b0}}    : state_mem_q[rd_ptr_q];
  assign out_if.out_cycle = empty_s ? {TS_WIDTH{1'b0}} : cycle_mem_q[rd_ptr_q];
  assign count            = count_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_fsm_trace_fifo.sv
// Directed bench: table of vectors for the change-only instance, hand-written
// sequences for fill/overflow, full push+pop, stamp wrap and async reset.
module tb_fsm_trace_fifo;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       clr1, en1, clr0, en0;
  logic [3:0] y1, y0;
  logic [4:0] count1, count0;
  logic       ovf1, ovf0;

  int checks   = 0;
  int failures = 0;

  fsm_trace_fifo_if #(.WIDTH(4), .TS_WIDTH(8)) if1 ();
  fsm_trace_fifo_if #(.WIDTH(4), .TS_WIDTH(8)) if0 ();

  fsm_trace_fifo #(.WIDTH(4), .TS_WIDTH(8), .DEPTH(16), .CHANGE_ONLY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clr1), .en(en1), .y(y1),
    .out_if(if1.master), .count(count1), .overflow(ovf1));

  fsm_trace_fifo #(.WIDTH(4), .TS_WIDTH(8), .DEPTH(16), .CHANGE_ONLY(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clr0), .en(en0), .y(y0),
    .out_if(if0.master), .count(count0), .overflow(ovf0));

  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [3:0] y;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [3:0] e_state;
    logic [7:0] e_cycle;
    logic [4:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [3:0] yy, input logic r, input logic c,
                     input logic v, input logic [3:0] s, input logic [7:0] cy,
                     input logic [4:0] n, input logic o);
    vec_t t;
    t.en = e; t.y = yy; t.rdy = r; t.clr = c;
    t.e_valid = v; t.e_state = s; t.e_cycle = cy; t.e_count = n; t.e_ovf = o;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk0(input string name, input logic v, input logic [3:0] s,
                      input logic [7:0] cy, input logic [4:0] n, input logic o);
    chk({name, ".valid"}, 32'(if0.out_valid), 32'(v));
    chk({name, ".state"}, 32'(if0.out_state), 32'(s));
    chk({name, ".cycle"}, 32'(if0.out_cycle), 32'(cy));
    chk({name, ".count"}, 32'(count0), 32'(n));
    chk({name, ".ovf"},   32'(ovf0), 32'(o));
  endtask

  // y pattern for the every-cycle instance: derived from the stamp it will carry.
  function automatic logic [3:0] ypat(input int stamp);
    logic [3:0] lo;
    lo = stamp[3:0];
    return lo ^ 4'hA;
  endfunction

  task automatic clear0();
    en0 = 1'b0; if0.out_ready = 1'b0; clr0 = 1'b1;
    step();
    clr0 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clr1 = 1'b0; en1 = 1'b0; y1 = 4'd0; if1.out_ready = 1'b0;
    clr0 = 1'b0; en0 = 1'b0; y0 = 4'd0; if0.out_ready = 1'b0;

    // reset state, before any clock edge
    #3;
    chk0("rst0", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);
    chk("rst1.valid", 32'(if1.out_valid), 32'd0);
    chk("rst1.count", 32'(count1), 32'd0);
    step();
    reset_n = 1'b1;

    // change-only instance: trace capture, drain, clear, enable gaps
    add(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 5'd1, 1'b0);
    add(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 5'd1, 1'b0);
    add(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 5'd2, 1'b0);
    add(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 5'd2, 1'b0);
    add(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 5'd2, 1'b0);
    add(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 5'd3, 1'b0);
    add(1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 4'd2, 8'd2, 5'd2, 1'b0);
    add(1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 8'd5, 5'd1, 1'b0);
    add(1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);
    add(1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);
    add(1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);
    add(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0, 5'd1, 1'b0);
    add(1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0, 5'd1, 1'b0);
    add(1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0, 5'd1, 1'b0);
    add(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0, 5'd1, 1'b0);
    add(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0, 5'd2, 1'b0);
    add(1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 8'd2, 5'd1, 1'b0);
    add(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);
    add(1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 4'd6, 8'd0, 5'd1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      en1 = vecs[i].en; y1 = vecs[i].y; if1.out_ready = vecs[i].rdy; clr1 = vecs[i].clr;
      step();
      chk($sformatf("vec%0d.valid", i), 32'(if1.out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.state", i), 32'(if1.out_state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d.cycle", i), 32'(if1.out_cycle), 32'(vecs[i].e_cycle));
      chk($sformatf("vec%0d.count", i), 32'(count1),        32'(vecs[i].e_count));
      chk($sformatf("vec%0d.ovf", i),   32'(ovf1),          32'(vecs[i].e_ovf));
    end
    en1 = 1'b0; clr1 = 1'b1; if1.out_ready = 1'b0;
    step();
    clr1 = 1'b0;

    // fill past full with every-cycle capture, then drain in order
    clear0();
    en0 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      y0 = ypat(k);
      step();
      if (k == 15) chk0("fill16", 1'b1, ypat(0), 8'd0, 5'd16, 1'b0);
      if (k == 16) chk0("fill17", 1'b1, ypat(0), 8'd0, 5'd16, 1'b1);
    end
    chk0("fill18", 1'b1, ypat(0), 8'd0, 5'd16, 1'b1);
    en0 = 1'b0; if0.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk(.name($sformatf("drain%0d.cycle", k)), .act(32'(if0.out_cycle)), .exp(32'(k)));
      chk(.name($sformatf("drain%0d.state", k)), .act(32'(if0.out_state)), .exp(32'(ypat(k))));
      step();
    end
    chk0("drained", 1'b0, 4'd0, 8'd0, 5'd0, 1'b1);
    clear0();
    chk0("clr_ovf", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);

    // full with simultaneous push and pop
    en0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      y0 = ypat(k);
      step();
    end
    y0 = ypat(16); if0.out_ready = 1'b1;
    step();
    chk0("full_pp", 1'b1, ypat(1), 8'd1, 5'd16, 1'b0);
    en0 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk(.name($sformatf("pp_drain%0d", k)), .act(32'(if0.out_cycle)), .exp(32'(k)));
      step();
    end
    chk("pp_empty", 32'(count0), 32'd0);

    // stamp wrap with continuous drain
    clear0();
    en0 = 1'b1; if0.out_ready = 1'b1;
    for (int k = 1; k <= 258; k++) begin
      y0 = ypat(k - 1);
      step();
      if (k <= 2 || k >= 254)
        chk0($sformatf("wrap%0d", k), 1'b1, ypat(k - 1), 8'((k - 1) % 256), 5'd1, 1'b0);
    end

    // asynchronous reset with five entries queued
    clear0();
    en0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      y0 = ypat(k);
      step();
    end
    en0 = 1'b0;
    chk("pre_rst.count", 32'(count0), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk0("async_rst", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk0("post_rst", 1'b0, 4'd0, 8'd0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
